// File: rtl/request_select_mux_pkg.sv
// Shared request-word layout for the round-robin scheduling kernels and their selectors.
// A request word is {addr, value, wr, valid}, with valid at bit 0.
package request_select_mux_pkg;

  localparam int ADDR_WIDTH     = 4;
  localparam int VALUE_WIDTH    = 8;

  localparam int REQ_VALID_BIT  = 0;
  localparam int REQ_WR_BIT     = 1;
  localparam int REQ_VALUE_LSB  = 2;
  localparam int REQ_ADDR_LSB   = REQ_VALUE_LSB + VALUE_WIDTH;

  localparam int REQ_WORD_WIDTH = ADDR_WIDTH + VALUE_WIDTH + 2;

  function automatic int req_width(input int addr_w, input int value_w);
    return addr_w + value_w + 2;
  endfunction

  // A one-entry selector still carries a 1-bit select so that the out-of-range index exists.
  function automatic int sel_width(input int req_number);
    return (req_number <= 1) ? 1 : $clog2(req_number);
  endfunction

endpackage

// File: rtl/request_select_mux.sv
// N-to-1 selector for packed request words, with an optional output register.
// Out-of-range select values produce an all-zero (invalid) request.
module request_select_mux
  import request_select_mux_pkg::*;
#(
  parameter int REQ_WIDTH       = REQ_WORD_WIDTH,
  parameter int REQ_NUMBER      = 2,
  parameter int REGISTER_OUTPUT = 0,
  localparam int SEL_WIDTH      = sel_width(REQ_NUMBER)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REQ_WIDTH-1:0] requests [REQ_NUMBER],
  input  logic [SEL_WIDTH-1:0] select,
  output logic [REQ_WIDTH-1:0] selected_request
);

  logic [REQ_WIDTH-1:0] selected_request_d;

  // Zero default covers every index past the last request, so the pivot may wrap freely.
  always_comb begin
    selected_request_d = '0;
    for (int i = 0; i < REQ_NUMBER; i++) begin
      if (int'(select) == i) begin
        selected_request_d = requests[i];
      end
    end
  end

  generate
    if (REGISTER_OUTPUT != 0) begin : g_reg
      logic [REQ_WIDTH-1:0] selected_request_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          selected_request_q <= '0;
        end else begin
          selected_request_q <= selected_request_d;
        end
      end

      assign selected_request = selected_request_q;
    end else begin : g_comb
      logic unused_clk_reset;

      assign unused_clk_reset = clk ^ reset;
      assign selected_request = selected_request_d;
    end
  endgenerate

endmodule

// File: tb/tb_request_select_mux.sv
// Self-checking bench for request_select_mux: combinational variants with N=1,2,3 and a registered N=3.
module tb_request_select_mux;

  logic        clk;
  logic        reset;

  logic [13:0] req1 [1];
  logic        sel1;
  logic [13:0] out1;

  logic [13:0] req2 [2];
  logic        sel2;
  logic [13:0] out2;

  logic [13:0] req3 [3];
  logic [1:0]  sel3;
  logic [13:0] out3;

  logic [13:0] reqr [3];
  logic [1:0]  selr;
  logic [13:0] outr;

  int total;
  int bad;

  request_select_mux #(.REQ_WIDTH(14), .REQ_NUMBER(1), .REGISTER_OUTPUT(0)) u_n1 (
    .clk(clk), .reset(reset), .requests(req1), .select(sel1), .selected_request(out1));
  request_select_mux #(.REQ_WIDTH(14), .REQ_NUMBER(2), .REGISTER_OUTPUT(0)) u_n2 (
    .clk(clk), .reset(reset), .requests(req2), .select(sel2), .selected_request(out2));
  request_select_mux #(.REQ_WIDTH(14), .REQ_NUMBER(3), .REGISTER_OUTPUT(0)) u_n3 (
    .clk(clk), .reset(reset), .requests(req3), .select(sel3), .selected_request(out3));
  request_select_mux #(.REQ_WIDTH(14), .REQ_NUMBER(3), .REGISTER_OUTPUT(1)) u_reg (
    .clk(clk), .reset(reset), .requests(reqr), .select(selr), .selected_request(outr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          inst;
    logic [1:0]  sel;
    logic [13:0] r0;
    logic [13:0] r1;
    logic [13:0] r2;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: an index into a list of n words; anything past the list is the empty request.
  function automatic logic [13:0] ref_pick(input logic [13:0] words [4], input int n, input int s);
    if (s < n) return words[s];
    return 14'h0000;
  endfunction

  function automatic vec_t mkv(input int inst, input logic [1:0] sel, input logic [13:0] r0,
                               input logic [13:0] r1, input logic [13:0] r2, input logic [13:0] exp);
    vec_t v;
    v.inst = inst; v.sel = sel; v.r0 = r0; v.r1 = r1; v.r2 = r2; v.exp = exp;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [13:0] words [4];
    logic [13:0] act;
    logic [13:0] prev_exp;
    logic [13:0] pend_exp;
    int          s;

    total = 0;
    bad   = 0;
    reset = 1'b1;
    req1[0] = '0;
    foreach (req2[i]) req2[i] = '0;
    foreach (req3[i]) req3[i] = '0;
    foreach (reqr[i]) reqr[i] = 14'h1111;
    sel1 = 0; sel2 = 0; sel3 = 0; selr = 2'd1;

    // Reset state of the registered variant, held across edges.
    #2;
    check("reg_reset_initial", outr, 14'h0000);
    @(posedge clk); #1;
    check("reg_reset_held", outr, 14'h0000);

    // Table-driven combinational vectors.
    vecs.push_back(mkv(2, 2'd0, 14'h1A5B, 14'h0F01, 14'h0000, 14'h1A5B));
    vecs.push_back(mkv(2, 2'd1, 14'h1A5B, 14'h0F01, 14'h0000, 14'h0F01));
    vecs.push_back(mkv(2, 2'd1, 14'h0F01, 14'h1A5B, 14'h0000, 14'h1A5B));
    vecs.push_back(mkv(2, 2'd1, 14'h0000, 14'h3FFE, 14'h0000, 14'h3FFE));
    vecs.push_back(mkv(2, 2'd1, 14'h3FFE, 14'h0001, 14'h0000, 14'h0001));
    vecs.push_back(mkv(2, 2'd0, 14'h2AAA, 14'h1555, 14'h0000, 14'h2AAA));
    vecs.push_back(mkv(3, 2'd0, 14'h0001, 14'h0002, 14'h0003, 14'h0001));
    vecs.push_back(mkv(3, 2'd1, 14'h0001, 14'h0002, 14'h0003, 14'h0002));
    vecs.push_back(mkv(3, 2'd2, 14'h0001, 14'h0002, 14'h0003, 14'h0003));
    vecs.push_back(mkv(3, 2'd3, 14'h0001, 14'h0002, 14'h0003, 14'h0000));
    vecs.push_back(mkv(3, 2'd3, 14'h3FFF, 14'h3FFF, 14'h3FFF, 14'h0000));
    vecs.push_back(mkv(1, 2'd0, 14'h3FFF, 14'h0000, 14'h0000, 14'h3FFF));
    vecs.push_back(mkv(1, 2'd1, 14'h3FFF, 14'h0000, 14'h0000, 14'h0000));

    foreach (vecs[k]) begin
      case (vecs[k].inst)
        1: begin req1[0] = vecs[k].r0; sel1 = vecs[k].sel[0]; end
        2: begin req2[0] = vecs[k].r0; req2[1] = vecs[k].r1; sel2 = vecs[k].sel[0]; end
        default: begin
          req3[0] = vecs[k].r0; req3[1] = vecs[k].r1; req3[2] = vecs[k].r2; sel3 = vecs[k].sel;
        end
      endcase
      #1;
      case (vecs[k].inst)
        1: act = out1;
        2: act = out2;
        default: act = out3;
      endcase
      check($sformatf("vec%0d_n%0d_sel%0d", k, vecs[k].inst, vecs[k].sel), act, vecs[k].exp);
    end

    // Randomized combinational sweep against the reference.
    for (int it = 0; it < 150; it++) begin
      for (int j = 0; j < 4; j++) words[j] = 14'($urandom);
      req1[0] = words[0];
      req2[0] = words[0]; req2[1] = words[1];
      req3[0] = words[0]; req3[1] = words[1]; req3[2] = words[2];
      sel1 = 1'($urandom_range(0, 1));
      sel2 = 1'($urandom_range(0, 1));
      sel3 = 2'($urandom_range(0, 3));
      #1;
      check("rand_n1", out1, ref_pick(words, 1, int'(sel1)));
      check("rand_n2", out2, ref_pick(words, 2, int'(sel2)));
      check("rand_n3", out3, ref_pick(words, 3, int'(sel3)));
    end

    // Release reset mid-cycle with select=1, requests[1]=2222: loads only at the next edge.
    @(negedge clk);
    reqr[0] = 14'h1111; reqr[1] = 14'h2222; reqr[2] = 14'h3333; selr = 2'd1;
    reset = 1'b0;
    #1;
    check("reg_release_before_edge", outr, 14'h0000);
    @(posedge clk); #1;
    check("reg_release_first_edge", outr, 14'h2222);

    // Select 0 -> 1: new request appears one edge later, holds between edges.
    reqr[0] = 14'h0AAA; reqr[1] = 14'h1555; selr = 2'd0;
    @(posedge clk); #1;
    check("reg_sel0", outr, 14'h0AAA);
    selr = 2'd1;
    #3;
    check("reg_hold_between_edges", outr, 14'h0AAA);
    @(posedge clk); #1;
    check("reg_sel1_next_edge", outr, 14'h1555);
    selr = 2'd3;
    @(posedge clk); #1;
    check("reg_out_of_range", outr, 14'h0000);

    // Asynchronous reset mid-cycle clears immediately and discards the pending value.
    selr = 2'd2;
    #2;
    reset = 1'b1;
    #1;
    check("reg_async_reset_mid_cycle", outr, 14'h0000);
    @(posedge clk); #1;
    check("reg_reset_discard_pending", outr, 14'h0000);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reg_release2_before_edge", outr, 14'h0000);
    @(posedge clk); #1;
    check("reg_release2_first_edge", outr, 14'h3333);

    // Randomized registered stream: one-cycle latency against the reference.
    for (int j = 0; j < 4; j++) words[j] = reqr[j < 3 ? j : 0];
    pend_exp = ref_pick(words, 3, int'(selr));
    for (int it = 0; it < 120; it++) begin
      for (int j = 0; j < 3; j++) begin
        words[j] = 14'($urandom);
        reqr[j]  = words[j];
      end
      s    = int'($urandom_range(0, 3));
      selr = 2'(s);
      prev_exp = pend_exp;
      pend_exp = ref_pick(words, 3, s);
      #2;
      check("reg_rand_hold", outr, prev_exp);
      @(posedge clk); #1;
      check("reg_rand_latency", outr, pend_exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
